uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Oversampling UART receiver that sits directly upstream of the receive FIFO.
- Converts the serial line into parallel bytes and presents each completed frame on Rx_Data together with a one-clock Data_Rdy pulse, which the FIFO uses as its write strobe.
- Checks start, parity and stop bits, and reports parity and framing errors alongside each frame.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first
OVERSAMPLE, 16, Baud_Tick pulses per bit period; must be even and >= 4
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

Ports:
Clk  input  1  system clock; all state changes on its rising edge
Rst  input  1  asynchronous, active-high reset
Baud_Tick  input  1  single-Clk enable pulse at OVERSAMPLE x baud rate
Rx_In  input  1  asynchronous serial line; idles high
BIST_Mode  input  1  1 = ignore Rx_In and treat the line as idle-high (the FIFO also suppresses writes in this mode)
Rx_Data  output  DATA_BITS  last completed frame's data; held until the next completion
Data_Rdy  output  1  one-Clk pulse when a frame completes with a valid stop bit
Parity_Err  output  1  parity result of the last completed frame
Frame_Err  output  1  1 = the last frame's stop bit sampled low
Rx_Busy  output  1  1 whenever the state is not IDLE

Behaviour:
- Reset values: Rx_Data = 0, Data_Rdy = 0, Parity_Err = 0, Frame_Err = 0, Rx_Busy = 0. The two-flop synchronizer resets to 1, the state to IDLE, and the tick and bit counters to 0.
- Line path: Rx_In passes through the two-flop synchronizer to give rx_s. When BIST_Mode = 1, rx_s is forced to 1.
- The tick counter (0..OVERSAMPLE-1) advances only on Baud_Tick. All sampling happens on Baud_Tick cycles.
- IDLE: on a Baud_Tick with rx_s = 0, clear the tick counter and go to START.
- START: at tick count OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s = 0: clear the tick counter, set bit count = 0, go to DATA.
  - rx_s = 1: false start (glitch); return to IDLE with no outputs changed.
- DATA: each time the tick counter wraps from OVERSAMPLE-1 to 0 (mid-bit), shift rx_s in LSB first and increment the bit counter.
  - After DATA_BITS samples, go to PARITY if PARITY_EN = 1, otherwise to STOP.
- PARITY: at the next mid-bit, store par_bad = (XOR of data bits XOR sampled bit XOR PARITY_ODD) != 0. Go to STOP.
- STOP: at the next mid-bit, sample rx_s.
  - rx_s = 1: on the next Clk edge, load Rx_Data, Parity_Err = par_bad (0 when PARITY_EN = 0), Frame_Err = 0, pulse Data_Rdy for exactly one Clk. Go to IDLE.
  - rx_s = 0: Frame_Err = 1, Parity_Err = par_bad, Rx_Data unchanged, no Data_Rdy. Go to BREAK.
- BREAK: wait until rx_s = 1 on a Baud_Tick, then go to IDLE. This prevents a held-low line from retriggering a start.
- Latency: Data_Rdy rises exactly one Clk after the Baud_Tick cycle that samples the stop bit. It is never high for two consecutive Clks.
- A frame with a parity error still delivers data: Data_Rdy pulses with Parity_Err = 1 in the same cycle.
- Error flags hold their value until the next frame completion (good frame or framing error).
- Back-to-back frames: a start edge is accepted on the first Baud_Tick after returning to IDLE; no extra idle bit is required beyond the stop bit.
- A Baud_Tick present while Rx_In changes is handled normally; only rx_s is ever sampled.
- Rst asserted mid-frame: all state clears immediately and the partial frame is discarded. After Rst releases, the block waits in IDLE for a new falling edge.
- Asserting BIST_Mode mid-frame makes the frame see 1s. The data bits become 1s and the stop bit is valid, so the frame completes normally.

Test Plan:
- Bench setup for all scenarios: Baud_Tick every 4 Clk, giving 64 Clk per bit; defaults DATA_BITS = 8, OVERSAMPLE = 16, even parity.
- Reset check: assert Rst mid-frame with Rx_In = 0 -> all outputs 0 immediately; no Data_Rdy until a full new frame is sent.
- Good frame: send 0xA5 with parity 0 and stop 1 -> one single-Clk Data_Rdy, Rx_Data = 0xA5, Parity_Err = 0, Frame_Err = 0, Rx_Busy low after the pulse.
- Parity error: send 0x3C with parity bit 1 -> Data_Rdy pulses, Rx_Data = 0x3C, Parity_Err = 1. A following good 0x01 frame clears Parity_Err to 0.
- Framing error: send 0x55 with stop bit 0, then hold the line low for 3 bit times -> Frame_Err = 1, no Data_Rdy, Rx_Data unchanged, no new frame until the line returns high.
- Glitch and throughput: a 2-bit-tick low pulse on an idle line -> no Rx_Busy after the mid-start check and no Data_Rdy. Then send frames 0x00, 0xFF, 0x81 back-to-back with a single stop bit each -> three Data_Rdy pulses carrying those values in order.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start/data/parity/stop framing with parity and
// framing error reporting, one-clock Data_Rdy strobe for the downstream FIFO.
module uart_rx_deserializer #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Baud_Tick,
   input  logic                 Rx_In,
   input  logic                 BIST_Mode,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Data_Rdy,
   output logic                 Parity_Err,
   output logic                 Frame_Err,
   output logic                 Rx_Busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q;
   logic [TW-1:0]        tick_q, tick_d, tick_nxt;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 rdy_q, rdy_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;
   logic                 rx_s;
   logic                 last_tick;

   assign rx_s      = BIST_Mode | sync2_q;
   assign last_tick = (tick_q == TICK_LAST);
   assign tick_nxt  = last_tick ? '0 : tick_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      data_d    = data_q;
      rdy_d     = 1'b0;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      if (Baud_Tick) begin
         unique case (state_q)
            IDLE: begin
               tick_d = '0;
               if (!rx_s) state_d = START;
            end
            START: begin
               // Mid start bit decides between a real frame and a glitch
               if (tick_q == TICK_MID) begin
                  tick_d = '0;
                  if (!rx_s) begin
                     bit_d   = '0;
                     state_d = DATA;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_nxt;
               end
            end
            DATA: begin
               tick_d = tick_nxt;
               if (last_tick) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_LAST)
                     state_d = PARITY_EN ? PARITY : STOP;
               end
            end
            PARITY: begin
               tick_d = tick_nxt;
               if (last_tick) begin
                  par_bad_d = (^shift_q) ^ rx_s ^ PARITY_ODD;
                  state_d   = STOP;
               end
            end
            STOP: begin
               tick_d = tick_nxt;
               if (last_tick) begin
                  perr_d = PARITY_EN ? par_bad_q : 1'b0;
                  if (rx_s) begin
                     data_d  = shift_q;
                     ferr_d  = 1'b0;
                     rdy_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = BREAK;
                  end
               end
            end
            BREAK: begin
               // A held-low line must go high before a new start counts
               tick_d = '0;
               if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         data_q    <= '0;
         rdy_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q   <= Rx_In;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         data_q    <= data_d;
         rdy_q     <= rdy_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   assign Rx_Data    = data_q;
   assign Data_Rdy   = rdy_q;
   assign Parity_Err = perr_q;
   assign Frame_Err  = ferr_q;
   assign Rx_Busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frame-level model of expected
// deliveries plus literal checks of flags after each scenario.
module tb_uart_rx_deserializer;

   localparam int BIT_CLKS = 64;

   logic       Clk;
   logic       Rst;
   logic       Baud_Tick;
   logic       Rx_In;
   logic       BIST_Mode;
   logic [7:0] Rx_Data;
   logic       Data_Rdy;
   logic       Parity_Err;
   logic       Frame_Err;
   logic       Rx_Busy;

   int vectors = 0;
   int miscompares = 0;
   int rdy_count = 0;
   logic busy_seen = 1'b0;

   logic [7:0] exp_d[$];
   logic       exp_p[$];

   uart_rx_deserializer dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Baud_Tick (Baud_Tick),
      .Rx_In     (Rx_In),
      .BIST_Mode (BIST_Mode),
      .Rx_Data   (Rx_Data),
      .Data_Rdy  (Data_Rdy),
      .Parity_Err(Parity_Err),
      .Frame_Err (Frame_Err),
      .Rx_Busy   (Rx_Busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Baud_Tick on every 4th clock
   initial begin
      int tcnt;
      tcnt = 0;
      Baud_Tick = 1'b0;
      forever begin
         @(negedge Clk);
         tcnt = (tcnt + 1) % 4;
         Baud_Tick = (tcnt == 0);
      end
   end

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_bit(input logic b);
      Rx_In = b;
      repeat (BIT_CLKS) @(negedge Clk);
   endtask

   // The model: a frame with a high stop bit on a live line must be
   // delivered; parity error if the count of ones incl. parity is odd.
   task automatic send_frame(input logic [7:0] d, input logic pbit,
                             input logic stop);
      if (stop && !BIST_Mode) begin
         exp_d.push_back(d);
         exp_p.push_back((($countones(d) + int'(pbit)) % 2) != 0);
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(pbit);
      send_bit(stop);
   endtask

   task automatic good(input logic [7:0] d);
      send_frame(d, logic'($countones(d) % 2), 1'b1);
   endtask

   // Compare process: each delivery against the model, hold otherwise
   initial begin
      logic [7:0] last;
      logic       prev;
      logic [7:0] d;
      logic       p;
      last = 8'h00;
      prev = 1'b0;
      forever begin
         @(negedge Clk);
         if (Rst) begin
            last = 8'h00;
            prev = 1'b0;
         end else begin
            if (Rx_Busy) busy_seen = 1'b1;
            if (Data_Rdy) begin
               rdy_count++;
               chk("rdy_single_cycle", {7'b0, prev}, 8'h00);
               if (exp_d.size() == 0) begin
                  chk("rdy_unexpected", 8'h01, 8'h00);
               end else begin
                  d = exp_d.pop_front();
                  p = exp_p.pop_front();
                  chk("rx_data", Rx_Data, d);
                  chk("parity_err", {7'b0, Parity_Err}, {7'b0, p});
                  chk("frame_err", {7'b0, Frame_Err}, 8'h00);
                  last = d;
               end
            end else begin
               chk("rx_data_hold", Rx_Data, last);
            end
            prev = Data_Rdy;
         end
      end
   end

   initial begin
      Rst = 1'b1;
      Rx_In = 1'b1;
      BIST_Mode = 1'b0;
      repeat (5) @(negedge Clk);
      chk("rst_rx_data", Rx_Data, 8'h00);
      chk("rst_data_rdy", {7'b0, Data_Rdy}, 8'h00);
      chk("rst_parity_err", {7'b0, Parity_Err}, 8'h00);
      chk("rst_frame_err", {7'b0, Frame_Err}, 8'h00);
      chk("rst_busy", {7'b0, Rx_Busy}, 8'h00);
      #2 Rst = 1'b0;
      repeat (BIT_CLKS) @(negedge Clk);

      // Good frame
      good(8'hA5);
      chk("a5_data", Rx_Data, 8'hA5);
      chk("a5_perr", {7'b0, Parity_Err}, 8'h00);
      chk("a5_ferr", {7'b0, Frame_Err}, 8'h00);
      chk("a5_busy", {7'b0, Rx_Busy}, 8'h00);

      // Reset mid-frame
      Rx_In = 1'b0;
      repeat (3 * BIT_CLKS) @(negedge Clk);
      #2 Rst = 1'b1;
      #1;
      chk("midrst_data", Rx_Data, 8'h00);
      chk("midrst_rdy", {7'b0, Data_Rdy}, 8'h00);
      chk("midrst_perr", {7'b0, Parity_Err}, 8'h00);
      chk("midrst_ferr", {7'b0, Frame_Err}, 8'h00);
      chk("midrst_busy", {7'b0, Rx_Busy}, 8'h00);
      Rx_In = 1'b1;
      repeat (4) @(negedge Clk);
      #2 Rst = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge Clk);
      chk("postrst_busy", {7'b0, Rx_Busy}, 8'h00);

      // Parity error, then a good frame clears it
      send_frame(8'h3C, 1'b1, 1'b1);
      chk("3c_data", Rx_Data, 8'h3C);
      chk("3c_perr", {7'b0, Parity_Err}, 8'h01);
      good(8'h01);
      chk("01_data", Rx_Data, 8'h01);
      chk("01_perr", {7'b0, Parity_Err}, 8'h00);

      // Framing error with the line held low
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (3 * BIT_CLKS) @(negedge Clk);
      chk("brk_ferr", {7'b0, Frame_Err}, 8'h01);
      chk("brk_perr", {7'b0, Parity_Err}, 8'h00);
      chk("brk_data", Rx_Data, 8'h01);
      chk("brk_busy", {7'b0, Rx_Busy}, 8'h01);
      Rx_In = 1'b1;
      repeat (BIT_CLKS) @(negedge Clk);
      chk("brk_release_busy", {7'b0, Rx_Busy}, 8'h00);

      // Glitch on an idle line
      busy_seen = 1'b0;
      Rx_In = 1'b0;
      repeat (8) @(negedge Clk);
      Rx_In = 1'b1;
      repeat (BIT_CLKS) @(negedge Clk);
      chk("glitch_seen_busy", {7'b0, busy_seen}, 8'h01);
      chk("glitch_busy", {7'b0, Rx_Busy}, 8'h00);
      chk("glitch_ferr_held", {7'b0, Frame_Err}, 8'h01);

      // BIST mode masks the line entirely
      BIST_Mode = 1'b1;
      busy_seen = 1'b0;
      send_frame(8'h00, 1'b0, 1'b1);
      BIST_Mode = 1'b0;
      chk("bist_busy", {7'b0, busy_seen}, 8'h00);

      // Back-to-back frames
      rdy_count = 0;
      good(8'h00);
      good(8'hFF);
      good(8'h81);
      chk("b2b_count", 8'(rdy_count), 8'h03);
      chk("b2b_data", Rx_Data, 8'h81);
      chk("b2b_ferr", {7'b0, Frame_Err}, 8'h00);
      chk("b2b_perr", {7'b0, Parity_Err}, 8'h00);

      repeat (BIT_CLKS) @(negedge Clk);
      chk("pending_frames", 8'(exp_d.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
